// File: rtl/sync_tx_sched_pkg.sv
// Shared types and constants for the transmit-side scheduler that feeds the sync_multi channel.
package sync_tx_sched_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitDone = 2'd2
    } state_e;

    localparam int unsigned DATA_MSB_DEF = 7;
    localparam int unsigned XFER_CNT_W   = 16;
    localparam int unsigned TIMER_W      = 16;
    localparam int unsigned TIMEOUT_DEF  = 255;

endpackage

// File: rtl/sync_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module sync_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    assign valid_o = |req_i;

    always_comb begin
        logic [IdxW-1:0] cand;
        logic            found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = IdxW'((int'(ptr_i) + k) % int'(NREQ));
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/sync_tx_sched.sv
// Round-robin transmit scheduler sharing one sync_multi channel; holds the word across the
// f/d handshake, acks the winner on done and flags a sticky error if a phase stalls.
module sync_tx_sched
    import sync_tx_sched_pkg::*;
#(
    parameter int unsigned DATA_MSB = DATA_MSB_DEF,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                       clk_tx,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*(DATA_MSB+1)-1:0] req_data,
    output logic [NREQ-1:0]            ack,
    output logic [NREQ-1:0]            gnt,
    output logic [DATA_MSB:0]          in_data,
    output logic                       v,
    input  logic                       f,
    input  logic                       d,
    output logic                       err,
    output logic [XFER_CNT_W-1:0]      xfer_cnt
);

    localparam int unsigned W    = DATA_MSB + 1;
    localparam int unsigned IdxW = $clog2(NREQ);

    state_e                state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [W-1:0]          data_q, data_d;
    logic                  err_q, err_d;
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;

    logic [NREQ-1:0]       pick_gnt;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic [W-1:0]          pick_data;
    logic [IdxW-1:0]       next_ptr;
    logic                  timeout_hit;
    logic                  complete;
    logic                  abort;

    sync_rr_pick #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_idx == IdxW'(i)) begin
                pick_data = req_data[i*W +: W];
            end
        end
    end

    assign next_ptr    = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    // Timer starts at 0 on phase entry, so TIMEOUT-1 marks the TIMEOUT-th cycle in the phase.
    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        err_d      = err_q;
        xfer_cnt_d = xfer_cnt_q;
        timer_d    = timer_q;
        complete   = 1'b0;
        abort      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid && !f) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    data_d  = pick_data;
                    timer_d = '0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = timer_q + 1'b1;
                if (d) begin
                    complete = 1'b1;
                end else if (f) begin
                    timer_d = '0;
                    state_d = StWaitDone;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            StWaitDone: begin
                timer_d = timer_q + 1'b1;
                if (d) begin
                    complete = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (complete) begin
            ack_d      = gnt_q;
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
        if (complete || abort) begin
            ptr_d   = next_ptr;
            gnt_d   = '0;
            state_d = StIdle;
        end
        if (abort) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_tx) begin
        if (!reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            ack_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
            timer_q    <= timer_d;
        end
    end

    assign ack      = ack_q;
    assign gnt      = gnt_q;
    assign in_data  = data_q;
    assign v        = (state_q == StLaunch);
    assign err      = err_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_sync_tx_sched.sv
// Directed bench for sync_tx_sched: inputs driven and outputs sampled on the falling edge.
module tb_sync_tx_sched;

    logic        clk_tx = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic [7:0]  in_data;
    logic        v;
    logic        f;
    logic        d;
    logic        err;
    logic [15:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_tx = ~clk_tx;

    sync_tx_sched #(
        .DATA_MSB (7),
        .NREQ     (4),
        .TIMEOUT  (8)
    ) dut (
        .clk_tx   (clk_tx),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .gnt      (gnt),
        .in_data  (in_data),
        .v        (v),
        .f        (f),
        .d        (d),
        .err      (err),
        .xfer_cnt (xfer_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_gnt;
        reset = 1'b0; req = '0; req_data = '0; f = 1'b0; d = 1'b0;
        repeat (3) @(negedge clk_tx);
        check_eq("rst_v", v, 0);
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_cnt", xfer_cnt, 0);
        check_eq("rst_data", in_data, 0);

        // Single word, f two cycles after v, d five cycles after v.
        reset = 1'b1; req = 4'b0001; req_data = 32'h0000_00A5;
        @(negedge clk_tx);
        check_eq("sw_v", v, 1);
        check_eq("sw_gnt", gnt, 4'b0001);
        check_eq("sw_data", in_data, 8'hA5);
        @(negedge clk_tx);
        check_eq("sw_v_hold", v, 1);
        f = 1'b1;
        @(negedge clk_tx);
        check_eq("sw_v_drop", v, 0);
        check_eq("sw_data_hold", in_data, 8'hA5);
        check_eq("sw_gnt_hold", gnt, 4'b0001);
        @(negedge clk_tx);
        @(negedge clk_tx);
        f = 1'b0; d = 1'b1;
        @(negedge clk_tx);
        check_eq("sw_ack", ack, 4'b0001);
        check_eq("sw_gnt_clr", gnt, 0);
        check_eq("sw_cnt", xfer_cnt, 1);
        check_eq("sw_data_done", in_data, 8'hA5);
        d = 1'b0; req = 4'b0000;
        @(negedge clk_tx);
        check_eq("sw_ack_pulse", ack, 0);

        // Fairness: all requesting, d three cycles after each launch.
        reset = 1'b0;
        @(negedge clk_tx);
        reset = 1'b1; req = 4'b1111; req_data = 32'h4433_2211;
        @(negedge clk_tx);
        for (int t = 0; t < 5; t++) begin
            exp_gnt = 4'b0001 << (t % 4);
            check_eq("rr_v", v, 1);
            check_eq("rr_gnt", gnt, exp_gnt);
            check_eq("rr_data", in_data, 32'h11 * ((t % 4) + 1));
            @(negedge clk_tx);
            @(negedge clk_tx);
            d = 1'b1;
            @(negedge clk_tx);
            check_eq("rr_ack", ack, exp_gnt);
            check_eq("rr_v_gap", v, 0);
            d = 1'b0;
            if (t == 4) req = 4'b0000;
            if (t < 4) begin
                @(negedge clk_tx);
                check_eq("rr_ack_pulse", ack, 0);
            end
        end
        @(negedge clk_tx);
        check_eq("rr_idle_v", v, 0);
        check_eq("rr_cnt", xfer_cnt, 5);

        // Busy gating: pointer now at 1.
        req = 4'b0010; f = 1'b1;
        repeat (3) @(negedge clk_tx);
        check_eq("busy_v", v, 0);
        check_eq("busy_gnt", gnt, 0);
        f = 1'b0;
        @(negedge clk_tx);
        check_eq("busy_rel_v", v, 1);
        check_eq("busy_rel_gnt", gnt, 4'b0010);
        check_eq("busy_rel_data", in_data, 8'h22);
        d = 1'b1;
        @(negedge clk_tx);
        check_eq("busy_ack", ack, 4'b0010);
        check_eq("busy_cnt", xfer_cnt, 6);
        d = 1'b0; req = 4'b0000;

        // Timeout with f stuck low: TIMEOUT=8.
        req = 4'b0100;
        @(negedge clk_tx);
        check_eq("to_v", v, 1);
        check_eq("to_gnt", gnt, 4'b0100);
        repeat (7) @(negedge clk_tx);
        check_eq("to_v_last", v, 1);
        check_eq("to_err_early", err, 0);
        @(negedge clk_tx);
        check_eq("to_v_drop", v, 0);
        check_eq("to_err", err, 1);
        check_eq("to_gnt_clr", gnt, 0);
        check_eq("to_no_ack", ack, 0);
        @(negedge clk_tx);
        check_eq("to_no_ack2", ack, 0);
        check_eq("to_cnt", xfer_cnt, 6);
        check_eq("to_retry_v", v, 1);
        check_eq("to_retry_gnt", gnt, 4'b0100);
        d = 1'b1;
        @(negedge clk_tx);
        check_eq("to_retry_ack", ack, 4'b0100);
        check_eq("to_retry_cnt", xfer_cnt, 7);
        check_eq("to_err_sticky", err, 1);
        d = 1'b0; req = 4'b0000;

        // Reset during WAIT_DONE: pointer at 3, done arrives with reset and is dropped.
        req = 4'b1001;
        @(negedge clk_tx);
        check_eq("mr_gnt", gnt, 4'b1000);
        check_eq("mr_data", in_data, 8'h44);
        f = 1'b1;
        @(negedge clk_tx);
        check_eq("mr_wait_v", v, 0);
        reset = 1'b0; d = 1'b1;
        @(negedge clk_tx);
        check_eq("mr_gnt_rst", gnt, 0);
        check_eq("mr_ack_rst", ack, 0);
        check_eq("mr_v_rst", v, 0);
        check_eq("mr_err_rst", err, 0);
        check_eq("mr_cnt_rst", xfer_cnt, 0);
        check_eq("mr_data_rst", in_data, 0);
        reset = 1'b1; d = 1'b0; f = 1'b0;
        @(negedge clk_tx);
        check_eq("mr_no_ack", ack, 0);
        check_eq("mr_restart_gnt", gnt, 4'b0001);
        check_eq("mr_restart_data", in_data, 8'h11);
        d = 1'b1;
        @(negedge clk_tx);
        check_eq("mr_ack", ack, 4'b0001);
        check_eq("mr_cnt", xfer_cnt, 1);
        d = 1'b0; req = 4'b0000;

        // Counter wrap from a preloaded 65535.
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        @(negedge clk_tx);
        check_eq("wrap_preload", xfer_cnt, 16'hFFFF);
        req = 4'b0010;
        @(negedge clk_tx);
        check_eq("wrap_gnt", gnt, 4'b0010);
        d = 1'b1;
        @(negedge clk_tx);
        check_eq("wrap_ack", ack, 4'b0010);
        check_eq("wrap_cnt", xfer_cnt, 0);
        d = 1'b0; req = 4'b0000;
        @(negedge clk_tx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
